// File: rtl/jtframe_ps2_joykeys.sv
// jtframe_ps2_joykeys
// PS/2 keyboard receiver plus arcade key mapper for up to four players.
// The raw pins are synchronised and glitch-filtered. Frames are deserialised
// with parity, stop-bit and timeout checks. The E0, F0 and E1 prefixes are
// tracked, and the scan codes drive level-per-key outputs.
//
// Ports (W = 4+BUTTONS):
//   clk, rst            system clock, synchronous active-high reset
//   ps2_clk, ps2_data   raw asynchronous PS/2 pins
//   key_joy             player p at [p*W +: W]: R,L,D,U, buttons 1..BUTTONS
//   key_start/key_coin  one bit per player
//   key_service/reset/pause, key_gfx[3:0]  system and debug keys
//   ev_valid/ev_code/ev_make  one strobe per completed scan code, {ext,code}
//   frame_err           one-cycle strobe on a parity, stop or timeout error
module jtframe_ps2_joykeys #(
    parameter int NPLAYERS = 2,
    parameter int BUTTONS  = 4,
    parameter int FILTER   = 4,
    parameter int TIMEOUT  = 60000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ps2_clk,
    input  logic                              ps2_data,
    output logic [NPLAYERS*(4+BUTTONS)-1:0]   key_joy,
    output logic [NPLAYERS-1:0]               key_start,
    output logic [NPLAYERS-1:0]               key_coin,
    output logic                              key_service,
    output logic                              key_reset,
    output logic                              key_pause,
    output logic [3:0]                        key_gfx,
    output logic                              ev_valid,
    output logic [8:0]                        ev_code,
    output logic                              ev_make,
    output logic                              frame_err
);
    localparam int W  = 4 + BUTTONS;
    localparam int TW = $clog2(TIMEOUT + 1);

    // Rows are players. Columns are R, L, D, U, then buttons 1..6. Bit 8 marks E0 codes.
    localparam logic [8:0] JOY_MAP [4][10] = '{
        '{9'h174, 9'h16B, 9'h172, 9'h175, 9'h014, 9'h011, 9'h029, 9'h012, 9'h01A, 9'h022},
        '{9'h034, 9'h023, 9'h02B, 9'h02D, 9'h01C, 9'h01B, 9'h015, 9'h01D, 9'h024, 9'h02C},
        '{9'h04B, 9'h03B, 9'h042, 9'h043, 9'h03A, 9'h031, 9'h033, 9'h035, 9'h03C, 9'h044},
        '{9'h074, 9'h06B, 9'h072, 9'h075, 9'h070, 9'h071, 9'h073, 9'h079, 9'h15A, 9'h069}
    };
    localparam logic [8:0] START_MAP [4] = '{9'h016, 9'h01E, 9'h026, 9'h025};
    localparam logic [8:0] COIN_MAP  [4] = '{9'h02E, 9'h036, 9'h03D, 9'h03E};
    localparam logic [8:0] GFX_MAP   [4] = '{9'h083, 9'h00A, 9'h001, 9'h009};

    // ---------------- synchroniser and clock filter ----------------
    logic       clk_s1_reg, clk_s2_reg, dat_s1_reg, dat_s2_reg;
    logic       filt_reg;
    logic [3:0] flt_cnt_reg;
    logic       flt_toggle, fall;

    // The filtered clock flips on the FILTER-th consecutive differing sample.
    assign flt_toggle = (clk_s2_reg != filt_reg) && (flt_cnt_reg == 4'(FILTER - 1));
    assign fall       = flt_toggle && filt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_reg  <= 1'b1;
            clk_s2_reg  <= 1'b1;
            dat_s1_reg  <= 1'b1;
            dat_s2_reg  <= 1'b1;
            filt_reg    <= 1'b1;
            flt_cnt_reg <= 4'd0;
        end else begin
            clk_s1_reg <= ps2_clk;
            clk_s2_reg <= clk_s1_reg;
            dat_s1_reg <= ps2_data;
            dat_s2_reg <= dat_s1_reg;
            if (clk_s2_reg != filt_reg) begin
                if (flt_toggle) begin
                    filt_reg    <= ~filt_reg;
                    flt_cnt_reg <= 4'd0;
                end else begin
                    flt_cnt_reg <= flt_cnt_reg + 4'd1;
                end
            end else begin
                flt_cnt_reg <= 4'd0;
            end
        end
    end

    // ---------------- frame receiver ----------------
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;
    state_t          state_reg;
    logic [2:0]      bit_cnt_reg;
    logic [7:0]      shift_reg;
    logic            par_reg;
    logic [TW-1:0]   tout_reg;
    logic            timed_out, stop_fall, frame_ok, byte_stb, err_stb;

    assign timed_out = (state_reg != ST_IDLE) && (tout_reg == TW'(TIMEOUT));
    assign stop_fall = fall && (state_reg == ST_STOP) && !timed_out;
    assign frame_ok  = dat_s2_reg && (^{shift_reg, par_reg});
    assign byte_stb  = stop_fall && frame_ok;
    assign err_stb   = timed_out || (stop_fall && !frame_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= 3'd0;
            shift_reg   <= 8'd0;
            par_reg     <= 1'b0;
            tout_reg    <= '0;
        end else begin
            // Saturates, so an idle line never produces a spurious timeout.
            if (fall)
                tout_reg <= '0;
            else if (tout_reg != TW'(TIMEOUT))
                tout_reg <= tout_reg + 1'b1;

            if (timed_out) begin
                state_reg <= ST_IDLE;
            end else if (fall) begin
                case (state_reg)
                    ST_IDLE: begin
                        if (!dat_s2_reg) begin
                            state_reg   <= ST_DATA;
                            bit_cnt_reg <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        shift_reg   <= {dat_s2_reg, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7)
                            state_reg <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_reg   <= dat_s2_reg;
                        state_reg <= ST_STOP;
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    // ---------------- scan-code decoder ----------------
    logic       ext_reg, rel_reg;
    logic [2:0] skip_reg;
    logic [8:0] code9;
    logic       in_skip, is_prefix, is_fake, key_stb, key_lvl;

    assign code9     = {ext_reg, shift_reg};
    assign in_skip   = (skip_reg != 3'd0);
    assign is_prefix = (shift_reg == 8'hE0) || (shift_reg == 8'hF0) || (shift_reg == 8'hE1);
    // E0 12 / E0 59 are shift codes the keyboard injects around navigation keys.
    assign is_fake   = (code9 == 9'h112) || (code9 == 9'h159);
    assign key_stb   = byte_stb && !in_skip && !is_prefix && !is_fake;
    assign key_lvl   = !rel_reg;

    logic       ev_valid_reg, ev_make_reg, frame_err_reg;
    logic [8:0] ev_code_reg;
    logic       service_reg, reset_reg, pause_reg;
    logic [3:0] gfx_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_reg       <= 1'b0;
            rel_reg       <= 1'b0;
            skip_reg      <= 3'd0;
            ev_valid_reg  <= 1'b0;
            ev_code_reg   <= 9'd0;
            ev_make_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            service_reg   <= 1'b0;
            reset_reg     <= 1'b0;
            pause_reg     <= 1'b0;
            gfx_reg       <= 4'd0;
        end else begin
            ev_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            if (err_stb) begin
                frame_err_reg <= 1'b1;
                ext_reg       <= 1'b0;
                rel_reg       <= 1'b0;
                skip_reg      <= 3'd0;
            end else if (byte_stb) begin
                if (in_skip) begin
                    // The Pause key sends E1 and then seven fixed bytes, reported as one event.
                    skip_reg <= skip_reg - 3'd1;
                    if (skip_reg == 3'd1) begin
                        ev_valid_reg <= 1'b1;
                        ev_code_reg  <= 9'h1E1;
                        ev_make_reg  <= 1'b1;
                    end
                end else if (shift_reg == 8'hE0) begin
                    ext_reg <= 1'b1;
                end else if (shift_reg == 8'hF0) begin
                    rel_reg <= 1'b1;
                end else if (shift_reg == 8'hE1) begin
                    skip_reg <= 3'd7;
                    ext_reg  <= 1'b0;
                    rel_reg  <= 1'b0;
                end else begin
                    ext_reg <= 1'b0;
                    rel_reg <= 1'b0;
                    if (!is_fake) begin
                        ev_valid_reg <= 1'b1;
                        ev_code_reg  <= code9;
                        ev_make_reg  <= !rel_reg;
                    end
                end
            end
            if (key_stb) begin
                case (code9)
                    9'h046:  service_reg <= key_lvl;
                    9'h004:  reset_reg   <= key_lvl;
                    9'h04D:  pause_reg   <= key_lvl;
                    default: ;
                endcase
                for (int i = 0; i < 4; i++)
                    if (code9 == GFX_MAP[i]) gfx_reg[i] <= key_lvl;
            end
        end
    end

    // ---------------- per-player key levels ----------------
    genvar gi;
    generate
        for (gi = 0; gi < NPLAYERS; gi++) begin : g_player
            logic [W-1:0] joy_reg;
            logic         start_reg, coin_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    joy_reg   <= '0;
                    start_reg <= 1'b0;
                    coin_reg  <= 1'b0;
                end else if (key_stb) begin
                    for (int b = 0; b < W; b++)
                        if (code9 == JOY_MAP[gi][b]) joy_reg[b] <= key_lvl;
                    if (code9 == START_MAP[gi]) start_reg <= key_lvl;
                    if (code9 == COIN_MAP[gi])  coin_reg  <= key_lvl;
                end
            end

            assign key_joy[gi*W +: W] = joy_reg;
            assign key_start[gi]      = start_reg;
            assign key_coin[gi]       = coin_reg;
        end
    endgenerate

    assign key_service = service_reg;
    assign key_reset   = reset_reg;
    assign key_pause   = pause_reg;
    assign key_gfx     = gfx_reg;
    assign ev_valid    = ev_valid_reg;
    assign ev_code     = ev_code_reg;
    assign ev_make     = ev_make_reg;
    assign frame_err   = frame_err_reg;

endmodule

// File: doc/jtframe_ps2_joykeys.md
# jtframe_ps2_joykeys

Integrated PS/2 keyboard receiver and arcade key mapper for up to four players. Deserialises PS/2 frames with glitch filtering, parity and timeout checks; tracks E0/F0/E1 prefixes; drives level-per-key joystick, start, coin and system outputs. Emits a raw make/break event stream for OSD/debug logic. Sits between the board PS/2 pins and the jtframe input mux.

## Interface
Parameters:
- NPLAYERS, 2, number of player maps decoded (1..4); keys of higher players ignored
- BUTTONS, 4, buttons per player (1..6)
- FILTER, 4, consecutive equal samples required before filtered ps2_clk changes (2..15)
- TIMEOUT, 60000, clk cycles without a filtered ps2_clk fall before an open frame is aborted

Ports (W = 4+BUTTONS):
- clk  in  1  system clock
- rst  in  1  reset (rst, synchronous, active-high); clock clk
- ps2_clk  in  1  raw PS/2 clock, asynchronous
- ps2_data  in  1  raw PS/2 data, asynchronous
- key_joy  out  NPLAYERS*W  player p at [p*W +: W]: bit0 right, 1 left, 2 down, 3 up, 4+ buttons 1..BUTTONS; active-high
- key_start  out  NPLAYERS  start per player
- key_coin  out  NPLAYERS  coin per player
- key_service, key_reset, key_pause  out  1 each
- key_gfx  out  4  layer-enable debug keys
- ev_valid  out  1  one-cycle strobe per completed scan code
- ev_code  out  9  {extended, code}
- ev_make  out  1  1 = make, 0 = break
- frame_err  out  1  one-cycle strobe on parity/stop/timeout error

## Operation
- Input: 2-flop synchronisers on both pins. Filtered clock toggles only after FILTER consecutive samples differ from its current value. Data sampled on filtered-clock falling edge.
- Receiver FSM: IDLE -> (start bit 0) DATA (8 bits LSB first) -> PARITY -> STOP -> IDLE. Start bit 1: stay IDLE, no error. Parity must be odd over data+parity; stop must be 1; otherwise frame_err, byte discarded, prefix flags cleared.
- Timeout counter clears on every filtered fall; in any state other than IDLE, reaching TIMEOUT -> IDLE + frame_err. Counter saturates in IDLE.
- Decoder on byte: E0 sets ext; F0 sets rel; E1 sets skip=7 (next 7 bytes swallowed, then one event 9'h1_E1, make=1, no key effect). Other bytes: ev_valid, ev_code={ext,byte}, ev_make=!rel, mapped output := !rel, then ext,rel cleared. 9'h1_12 and 9'h1_59 (fake shifts): flags cleared, no event.
- Map (hex, E0-prefixed as 1_xx): P1 dirs R 1_74, L 1_6B, D 1_72, U 1_75, buttons 14,11,29,12,1A,22. P2 dirs 34,23,2B,2D, buttons 1C,1B,15,1D,24,2C. P3 dirs 4B,3B,42,43, buttons 3A,31,33,35,3C,44. P4 (keypad) dirs 74,6B,72,75 non-extended, buttons 70,71,73,79,1_5A,69. Buttons beyond BUTTONS unmapped.
- Start 16,1E,26,25; coin 2E,36,3D,3E (players 1..4, only if < NPLAYERS). Service 46; reset 04; pause 4D; gfx[0..3] 83,0A,01,09.
- Repeated make (typematic) re-asserts the same level; ev_valid still strobes.
- frame_err does not alter key levels.

## Timing
- Reset: all outputs 0, FSM IDLE, ext=rel=0, skip=0, filter state high, counter 0.
- Byte complete at cycle T (stop sampled). Key outputs, ev_* update at T+1; ev_valid/frame_err high exactly one cycle.
- Pin-to-filtered latency: 2 sync + FILTER cycles.
- rst mid-frame: frame dropped, no event after release; next frame decoded normally.
- Error during skip window: skip cleared.

## Test plan
- P1 Up: frames E0,75 -> key_joy[3]=1, ev_code 9'h1_75 make; then E0,F0,75 -> key_joy[3]=0, ev_make=0.
- NPLAYERS=2, BUTTONS=4: send 3B -> no key_joy change, ev_valid with 9'h0_3B; send 2D -> key_joy[8+3]=1.
- Parity corrupted frame for 29 -> frame_err pulse, key_joy[6] stays 0, next valid 29 sets it.
- Stop after 5 data bits, idle TIMEOUT cycles -> frame_err, FSM IDLE; following 16 frame sets key_start[0].
- Pause sequence E1,14,77,E1,F0,14,F0,77 -> single ev 9'h1_E1; key_joy[4] (Ctrl) unchanged.
- Glitch on ps2_clk shorter than FILTER cycles mid-frame -> byte decoded correctly, no frame_err.
